// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Purpose:
//   Execute-side partner of the fetch-stage branch predictor. Fetch pushes every
//   predicted conditional branch / jalr (PC, predicted direction, predicted
//   target) into an in-order circular queue. Execute resolves the oldest entry
//   with the real outcome. A correct prediction simply retires the head. A
//   wrong prediction flushes the whole queue and raises a registered one-cycle
//   redirect to fetch, during which the block neither accepts pushes nor
//   resolves. Sticky error flags and saturating perf counters are kept.
//
// Ports:
//   clk            in   core clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   fet_push       in   fetch pushes a prediction (taken only when fet_ready=1)
//   fet_ready      out  queue not full and not redirecting
//   fet_pc         in   PC of the predicted instruction
//   fet_taken      in   predicted direction
//   fet_target     in   predicted target
//   exe_res_valid  in   execute resolves the oldest outstanding branch
//   exe_pc         in   PC of the resolved instruction
//   exe_taken      in   actual direction
//   exe_target     in   actual taken target
//   redirect_valid out  one-cycle pulse: fetch must restart at redirect_pc
//   redirect_pc    out  restart address captured at the mispredict
//   q_count        out  current occupancy (0..DEPTH)
//   err_underflow  out  sticky: resolve seen while the queue was empty
//   err_order      out  sticky: resolved PC differed from the head PC
//   mispred_cnt    out  saturating mispredict count
//   resolve_cnt    out  saturating count of resolves accepted in RUN
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fet_push,
  output logic            fet_ready,
  input  logic [XLEN-1:0] fet_pc,
  input  logic            fet_taken,
  input  logic [XLEN-1:0] fet_target,
  input  logic            exe_res_valid,
  input  logic [XLEN-1:0] exe_pc,
  input  logic            exe_taken,
  input  logic [XLEN-1:0] exe_target,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [AW:0]     q_count,
  output logic            err_underflow,
  output logic            err_order,
  output logic [15:0]     mispred_cnt,
  output logic [15:0]     resolve_cnt
);

  localparam logic [AW:0] LP_FULL = DEPTH[AW:0];
  localparam logic [15:0] LP_SAT  = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Queue storage (no reset needed: occupancy decides what is valid)
  logic [XLEN-1:0] r_mem_pc     [DEPTH];
  logic            r_mem_taken  [DEPTH];
  logic [XLEN-1:0] r_mem_target [DEPTH];

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_err_underflow;
  logic            r_err_order;
  logic [15:0]     r_mispred_cnt;
  logic [15:0]     r_resolve_cnt;

  logic            w_run;
  logic            w_full;
  logic            w_empty;
  logic            w_ready;
  logic            w_resolve;
  logic            w_res_hit;
  logic            w_pc_diff;
  logic            w_mismatch;
  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_head_pc;
  logic            w_head_taken;
  logic [XLEN-1:0] w_head_target;
  logic [XLEN-1:0] w_restart_pc;

  // ---------------------------------------------------------------------------
  // Status and head decode
  // ---------------------------------------------------------------------------
  assign w_run    = (r_state == ST_RUN);
  assign w_full   = (r_count == LP_FULL);
  assign w_empty  = (r_count == '0);
  // Ready depends only on registered state: a pop in the same cycle does not
  // open a slot for fetch, keeping pop->ready off the combinational path.
  assign w_ready  = ~w_full & w_run;

  assign w_head_pc     = r_mem_pc[r_rd_ptr];
  assign w_head_taken  = r_mem_taken[r_rd_ptr];
  assign w_head_target = r_mem_target[r_rd_ptr];

  assign w_resolve  = exe_res_valid & w_run;
  assign w_res_hit  = w_resolve & ~w_empty;
  assign w_pc_diff  = (exe_pc != w_head_pc);
  // Target only matters when the branch was actually taken.
  assign w_mismatch = w_res_hit &
                      (w_pc_diff |
                       (exe_taken != w_head_taken) |
                       (exe_taken & (exe_target != w_head_target)));
  assign w_pop      = w_res_hit & ~w_mismatch;
  // A push that coincides with a mispredict belongs to the wrong path: drop it.
  assign w_push     = fet_push & w_ready & ~w_mismatch;

  assign w_restart_pc = exe_taken ? exe_target : (exe_pc + XLEN'(4));

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_mismatch) w_state_next = ST_REDIR;
      ST_REDIR: w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue storage write
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]     <= fet_pc;
      r_mem_taken[r_wr_ptr]  <= fet_taken;
      r_mem_target[r_wr_ptr] <= fet_target;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_mismatch) begin
      // Flush: everything younger than the mispredicted branch is discarded.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mismatch;
      if (w_mismatch) r_redirect_pc <= w_restart_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky errors and saturating counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_underflow <= 1'b0;
      r_err_order     <= 1'b0;
      r_mispred_cnt   <= '0;
      r_resolve_cnt   <= '0;
    end else begin
      if (w_resolve & w_empty)    r_err_underflow <= 1'b1;
      if (w_mismatch & w_pc_diff) r_err_order     <= 1'b1;
      if (w_mismatch && (r_mispred_cnt != LP_SAT)) begin
        r_mispred_cnt <= r_mispred_cnt + 16'd1;
      end
      if (w_resolve && (r_resolve_cnt != LP_SAT)) begin
        r_resolve_cnt <= r_resolve_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fet_ready      = w_ready;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign q_count        = r_count;
  assign err_underflow  = r_err_underflow;
  assign err_order      = r_err_order;
  assign mispred_cnt    = r_mispred_cnt;
  assign resolve_cnt    = r_resolve_cnt;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_queue
//
// Purpose:
//   Directed-vector bench for branch_resolve_queue. A queue-based behavioural
//   model tracks expected outputs; a compare process checks every output on
//   every falling clock edge, and literal expectations pin key values.
// -----------------------------------------------------------------------------
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst_n;
  logic            fet_push;
  logic            fet_ready;
  logic [XLEN-1:0] fet_pc;
  logic            fet_taken;
  logic [XLEN-1:0] fet_target;
  logic            exe_res_valid;
  logic [XLEN-1:0] exe_pc;
  logic            exe_taken;
  logic [XLEN-1:0] exe_target;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [AW:0]     q_count;
  logic            err_underflow;
  logic            err_order;
  logic [15:0]     mispred_cnt;
  logic [15:0]     resolve_cnt;

  branch_resolve_queue #(.DEPTH(DEPTH), .AW(AW), .XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fet_push       (fet_push),
    .fet_ready      (fet_ready),
    .fet_pc         (fet_pc),
    .fet_taken      (fet_taken),
    .fet_target     (fet_target),
    .exe_res_valid  (exe_res_valid),
    .exe_pc         (exe_pc),
    .exe_taken      (exe_taken),
    .exe_target     (exe_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .q_count        (q_count),
    .err_underflow  (err_underflow),
    .err_order      (err_order),
    .mispred_cnt    (mispred_cnt),
    .resolve_cnt    (resolve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_print  = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m_q[$];
  bit          m_redir;
  logic [31:0] m_rpc;
  int          m_mis;
  int          m_res;
  bit          m_eu;
  bit          m_eo;

  task automatic model_reset();
    m_q.delete();
    m_redir = 0;
    m_rpc   = '0;
    m_mis   = 0;
    m_res   = 0;
    m_eu    = 0;
    m_eo    = 0;
  endtask

  // Applies one clock edge worth of behaviour using the inputs that were
  // stable across that edge.
  task automatic model_update();
    bit   ready_before;
    bit   mis;
    ent_t h;
    ent_t e;
    ready_before = (m_q.size() < DEPTH) && !m_redir;
    mis = 0;
    if (m_redir) begin
      m_redir = 0;
    end else begin
      if (exe_res_valid) begin
        if (m_res < 65535) m_res++;
        if (m_q.size() == 0) begin
          m_eu = 1;
        end else begin
          h = m_q[0];
          mis = (exe_pc != h.pc) || (exe_taken != h.taken) ||
                (exe_taken && (exe_target != h.tgt));
          if (mis) begin
            m_q.delete();
            m_redir = 1;
            m_rpc   = exe_taken ? exe_target : exe_pc + 32'd4;
            if (m_mis < 65535) m_mis++;
            if (exe_pc != h.pc) m_eo = 1;
          end else begin
            void'(m_q.pop_front());
          end
        end
      end
      if (fet_push && ready_before && !mis) begin
        e.pc = fet_pc; e.taken = fet_taken; e.tgt = fet_target;
        m_q.push_back(e);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
      end
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    cmp("fet_ready",      64'(fet_ready),      64'((m_q.size() < DEPTH) && !m_redir));
    cmp("redirect_valid", 64'(redirect_valid), 64'(m_redir));
    cmp("redirect_pc",    64'(redirect_pc),    64'(m_rpc));
    cmp("q_count",        64'(q_count),        64'(m_q.size()));
    cmp("err_underflow",  64'(err_underflow),  64'(m_eu));
    cmp("err_order",      64'(err_order),      64'(m_eo));
    cmp("mispred_cnt",    64'(mispred_cnt),    64'(m_mis));
    cmp("resolve_cnt",    64'(resolve_cnt),    64'(m_res));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input bit p, input logic [31:0] ppc, input bit pt, input logic [31:0] ptg,
                      input bit r, input logic [31:0] rpc, input bit rt, input logic [31:0] rtg);
    fet_push      = p;
    fet_pc        = ppc;
    fet_taken     = pt;
    fet_target    = ptg;
    exe_res_valid = r;
    exe_pc        = rpc;
    exe_taken     = rt;
    exe_target    = rtg;
    @(posedge clk);
    #1;
    if (rst_n) model_update();
  endtask

  task automatic push(input logic [31:0] ppc, input bit pt, input logic [31:0] ptg);
    step(1, ppc, pt, ptg, 0, 0, 0, 0);
    $display("push pc=%h taken=%0d tgt=%h -> count=%0d ready=%0d", ppc, pt, ptg, q_count, fet_ready);
  endtask

  task automatic resolve(input logic [31:0] rpc, input bit rt, input logic [31:0] rtg);
    step(0, 0, 0, 0, 1, rpc, rt, rtg);
    $display("resolve pc=%h taken=%0d tgt=%h -> count=%0d redir=%0d rpc=%h", rpc, rt, rtg, q_count, redirect_valid, redirect_pc);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    fet_push = 0; fet_pc = '0; fet_taken = 0; fet_target = '0;
    exe_res_valid = 0; exe_pc = '0; exe_taken = 0; exe_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    cmp("rst_ready", 64'(fet_ready), 64'd1);
    cmp("rst_count", 64'(q_count), 64'd0);
    cmp("rst_redir", 64'(redirect_valid), 64'd0);

    // 1: correct prediction retires
    push(32'h100, 1, 32'h140);
    cmp("t1_count_after_push", 64'(q_count), 64'd1);
    resolve(32'h100, 1, 32'h140);
    cmp("t1_count", 64'(q_count), 64'd0);
    cmp("t1_resolve_cnt", 64'(resolve_cnt), 64'd1);
    cmp("t1_no_redir", 64'(redirect_valid), 64'd0);

    // 2: direction mispredict, redirect to actual target
    push(32'h200, 0, 32'h0);
    resolve(32'h200, 1, 32'h280);
    cmp("t2_redir", 64'(redirect_valid), 64'd1);
    cmp("t2_rpc", 64'(redirect_pc), 64'h280);
    cmp("t2_mispred", 64'(mispred_cnt), 64'd1);
    cmp("t2_ready_redir", 64'(fet_ready), 64'd0);
    idle();
    cmp("t2_redir_drop", 64'(redirect_valid), 64'd0);
    cmp("t2_ready_back", 64'(fet_ready), 64'd1);

    // 3: predicted taken, actually not taken; younger entries and a
    //    same-cycle push are flushed
    push(32'h300, 1, 32'h340);
    push(32'h308, 0, 32'h0);
    push(32'h310, 1, 32'h400);
    step(1, 32'h320, 1, 32'h360, 1, 32'h300, 0, 32'h0);
    cmp("t3_rpc", 64'(redirect_pc), 64'h304);
    cmp("t3_flushed", 64'(q_count), 64'd0);
    idle();
    cmp("t3_count_after", 64'(q_count), 64'd0);

    // 4: fill, overflow push ignored, in-order resolve across pointer wrap
    push(32'h10, 1, 32'h50);
    push(32'h14, 0, 32'h0);
    push(32'h18, 1, 32'h90);
    push(32'h1C, 1, 32'hA0);
    cmp("t4_full_ready", 64'(fet_ready), 64'd0);
    push(32'h99, 1, 32'h99);
    cmp("t4_full_count", 64'(q_count), 64'd4);
    resolve(32'h10, 1, 32'h50);
    step(1, 32'h20, 1, 32'hB0, 1, 32'h14, 0, 32'h0);
    cmp("t4_net_count", 64'(q_count), 64'd3);
    resolve(32'h18, 1, 32'h90);
    resolve(32'h1C, 1, 32'hA0);
    resolve(32'h20, 1, 32'hB0);
    cmp("t4_empty", 64'(q_count), 64'd0);
    cmp("t4_no_redir", 64'(redirect_valid), 64'd0);
    cmp("t4_resolve_cnt", 64'(resolve_cnt), 64'd8);
    cmp("t4_mispred", 64'(mispred_cnt), 64'd2);

    // 5: underflow and order errors
    resolve(32'h0, 0, 32'h0);
    cmp("t5_uf", 64'(err_underflow), 64'd1);
    cmp("t5_uf_noredir", 64'(redirect_valid), 64'd0);
    idle();
    cmp("t5_uf_sticky", 64'(err_underflow), 64'd1);
    push(32'h400, 1, 32'h480);
    resolve(32'h500, 1, 32'h480);
    cmp("t5_order", 64'(err_order), 64'd1);
    cmp("t5_redir", 64'(redirect_valid), 64'd1);
    cmp("t5_rpc", 64'(redirect_pc), 64'h480);
    idle();

    // 6: asynchronous reset in the middle of a redirect
    push(32'h600, 1, 32'h640);
    resolve(32'h600, 0, 32'h0);
    cmp("t6_redir_pre", 64'(redirect_valid), 64'd1);
    fet_push = 0; exe_res_valid = 0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("t6_rst_redir", 64'(redirect_valid), 64'd0);
    cmp("t6_rst_count", 64'(q_count), 64'd0);
    cmp("t6_rst_err", 64'(err_order), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();
    cmp("t6_ready", 64'(fet_ready), 64'd1);
    cmp("t6_mispred_zero", 64'(mispred_cnt), 64'd0);

    // Saturation of resolve_cnt via repeated resolves on an empty queue
    for (int i = 0; i < 65536; i++) begin
      step(0, 0, 0, 0, 1, 0, 0, 0);
    end
    $display("saturate resolves -> resolve_cnt=%h", resolve_cnt);
    cmp("sat_resolve", 64'(resolve_cnt), 64'hFFFF);
    push(32'h700, 1, 32'h740);
    resolve(32'h700, 0, 32'h0);
    cmp("sat_resolve_hold", 64'(resolve_cnt), 64'hFFFF);
    cmp("sat_mispred", 64'(mispred_cnt), 64'd1);
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
